// File: rtl/axi_ram_init_ctrl.sv
// ---------------------------------------------------------------------------
// axi_ram_init_ctrl
//
// Preloads the 64-bit AXI RAM before the core is released. Each run writes
// NUM_WORDS consecutive 64-bit words starting at BASE_ADDR, using one
// single-beat INCR burst per word. Only one write is in flight at a time.
// The data source is chosen when the run starts:
//   fill mode   : every word is the i_fill_data value captured at start
//   stream mode : words are taken one by one from a valid/ready stream
//
// Ports
//   clk, rst                clock, synchronous active-high reset
//   i_start                 start a run (honoured only in IDLE/DONE/ERR)
//   i_fill_mode             1 = constant fill, 0 = stream (sampled at start)
//   i_fill_data             constant fill word
//   i_s_data/i_s_valid      loader word stream
//   o_s_ready               stream ready (high only while fetching)
//   o_aw*, i_awready        AXI write-address channel
//   o_w*, i_wready          AXI write-data channel
//   i_b*, o_bready          AXI write-response channel
//   o_busy                  controller owns the RAM write channels
//   o_init_done             sticky, run finished with every response OKAY
//   o_init_error            sticky, run aborted on a bad response
//   o_words_done            words acknowledged OKAY in the current run
//
// BASE_ADDR must be 8-byte aligned, and NUM_WORDS must lie in
// 1..2^(ADDR_WIDTH-3).
// ---------------------------------------------------------------------------
module axi_ram_init_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 6,
    parameter int AXI_ID     = 0,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_fill_mode,
    input  logic [63:0]           i_fill_data,
    input  logic [63:0]           i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic [ID_WIDTH-1:0]   o_awid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [7:0]            o_awlen,
    output logic [2:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [63:0]           o_wdata,
    output logic [7:0]            o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [ID_WIDTH-1:0]   i_bid,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    output logic                  o_busy,
    output logic                  o_init_done,
    output logic                  o_init_error,
    output logic [ADDR_WIDTH-3:0] o_words_done
);

    localparam int CNT_W = ADDR_WIDTH - 2;

    localparam logic [ID_WIDTH-1:0]   ID_C   = ID_WIDTH'(AXI_ID);
    localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W-1:0]      NUM_C  = CNT_W'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        RESP,
        DONE,
        ERR
    } state_t;

    state_t state;

    logic fill_mode;   // source selected at start
    logic aw_done;     // address accepted for the current word
    logic w_done;      // data accepted for the current word

    // Fixed burst shape: one full 8-byte beat per burst.
    assign o_awid    = ID_C;
    assign o_awlen   = 8'd0;
    assign o_awsize  = 3'd3;
    assign o_awburst = 2'b01;
    assign o_wstrb   = 8'hFF;
    assign o_wlast   = 1'b1;

    logic aw_hs, w_hs, b_hs, b_bad;
    logic aw_fin, w_fin;
    logic [CNT_W-1:0] cnt_inc;

    assign aw_hs   = o_awvalid & i_awready;
    assign w_hs    = o_wvalid & i_wready;
    assign b_hs    = o_bready & i_bvalid;
    assign b_bad   = (i_bresp != 2'b00) || (i_bid != ID_C);
    // A channel counts as finished if it completed earlier or handshakes now,
    // so both finishing in the same cycle moves straight to RESP.
    assign aw_fin  = aw_done | aw_hs;
    assign w_fin   = w_done | w_hs;
    assign cnt_inc = o_words_done + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fill_mode    <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            o_s_ready    <= 1'b0;
            o_awvalid    <= 1'b0;
            o_wvalid     <= 1'b0;
            o_bready     <= 1'b0;
            o_busy       <= 1'b0;
            o_init_done  <= 1'b0;
            o_init_error <= 1'b0;
            o_words_done <= '0;
            o_awaddr     <= BASE_C;
            o_wdata      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        o_init_done  <= 1'b0;
                        o_init_error <= 1'b0;
                        o_words_done <= '0;
                        o_awaddr     <= BASE_C;
                        fill_mode    <= i_fill_mode;
                        o_busy       <= 1'b1;
                        if (i_fill_mode) begin
                            o_wdata   <= i_fill_data;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            o_s_ready <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (i_s_valid) begin
                        o_wdata   <= i_s_data;
                        o_s_ready <= 1'b0;
                        o_awvalid <= 1'b1;
                        o_wvalid  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    // Each channel drops its valid on its own handshake;
                    // address and data registers are untouched here.
                    if (aw_hs) o_awvalid <= 1'b0;
                    if (w_hs)  o_wvalid  <= 1'b0;
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) begin
                        o_bready <= 1'b1;
                        state    <= RESP;
                    end
                end

                RESP: begin
                    if (b_hs) begin
                        o_bready <= 1'b0;
                        if (b_bad) begin
                            o_init_error <= 1'b1;
                            o_busy       <= 1'b0;
                            state        <= ERR;
                        end else begin
                            o_words_done <= cnt_inc;
                            // Address wraps modulo 2^ADDR_WIDTH by width.
                            o_awaddr     <= o_awaddr + STEP_C;
                            if (cnt_inc == NUM_C) begin
                                o_init_done <= 1'b1;
                                o_busy      <= 1'b0;
                                state       <= DONE;
                            end else if (fill_mode) begin
                                o_awvalid <= 1'b1;
                                o_wvalid  <= 1'b1;
                                aw_done   <= 1'b0;
                                w_done    <= 1'b0;
                                state     <= WRITE;
                            end else begin
                                o_s_ready <= 1'b1;
                                state     <= FETCH;
                            end
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    o_s_ready <= 1'b0;
                    o_awvalid <= 1'b0;
                    o_wvalid  <= 1'b0;
                    o_bready  <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_init_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_ram_init_ctrl
//
// Directed bench. u_dut (NUM_WORDS=4, BASE_ADDR=0) sits on a small AXI RAM
// model with programmable AW stall and bad-response injection. u_wrap
// (NUM_WORDS=2, BASE_ADDR=0xFFF8) sits on an always-ready responder and
// exercises address wrap.
// ---------------------------------------------------------------------------
module tb_axi_ram_init_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, fill_mode, s_valid;
    logic [63:0] fill_data, s_data;

    logic        s_ready, awvalid, awready, wvalid, wready, wlast;
    logic        bvalid, bready, busy, done, err;
    logic [5:0]  awid, bid;
    logic [15:0] awaddr;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [63:0] wdata;
    logic [13:0] words_done;

    axi_ram_init_ctrl #(
        .ADDR_WIDTH(16), .ID_WIDTH(6), .AXI_ID(0), .BASE_ADDR(0), .NUM_WORDS(4)
    ) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_fill_mode(fill_mode),
        .i_fill_data(fill_data), .i_s_data(s_data), .i_s_valid(s_valid),
        .o_s_ready(s_ready), .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen),
        .o_awsize(awsize), .o_awburst(awburst), .o_awvalid(awvalid),
        .i_awready(awready), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .o_wvalid(wvalid), .i_wready(wready), .i_bid(bid), .i_bresp(bresp),
        .i_bvalid(bvalid), .o_bready(bready), .o_busy(busy),
        .o_init_done(done), .o_init_error(err), .o_words_done(words_done)
    );

    // RAM model for u_dut
    logic [63:0] mem [0:8191];
    logic        aw_got, w_got, bpend;
    logic [15:0] aw_q, c_addr;
    logic [63:0] w_q, c_data;
    int          aw_wait, aw_delay, wr_cnt, b_idx, bad_idx;

    assign awready = !aw_got && (aw_wait >= aw_delay);
    assign wready  = !w_got;
    assign bvalid  = bpend;
    assign bid     = 6'd0;
    assign bresp   = (b_idx == bad_idx) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0;
            aw_wait <= 0; wr_cnt <= 0; b_idx <= 0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_q <= awaddr; aw_wait <= 0; end
            if (wvalid && wready) begin w_got <= 1'b1; w_q <= wdata; end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bpend) begin
                c_addr = aw_got ? aw_q : awaddr;
                c_data = w_got ? w_q : wdata;
                mem[c_addr[15:3]] <= c_data;
                bpend  <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                wr_cnt <= wr_cnt + 1;
            end
            if (bvalid && bready) begin bpend <= 1'b0; b_idx <= b_idx + 1; end
        end
    end

    // Stream ready must never coexist with an active AXI phase.
    int ready_viol = 0;
    always @(negedge clk)
        if (s_ready && (awvalid || wvalid || bready)) ready_viol <= ready_viol + 1;

    // Wrap instance with an always-ready responder
    logic        start2, s_ready2, awvalid2, wvalid2, wlast2, bready2, busy2, done2, err2, bpend2;
    logic [5:0]  awid2;
    logic [15:0] awaddr2;
    logic [7:0]  awlen2, wstrb2;
    logic [2:0]  awsize2;
    logic [1:0]  awburst2;
    logic [63:0] wdata2;
    logic [13:0] words_done2;

    axi_ram_init_ctrl #(
        .ADDR_WIDTH(16), .ID_WIDTH(6), .AXI_ID(0), .BASE_ADDR(16'hFFF8), .NUM_WORDS(2)
    ) u_wrap (
        .clk(clk), .rst(rst), .i_start(start2), .i_fill_mode(1'b1),
        .i_fill_data(fill_data), .i_s_data(64'd0), .i_s_valid(1'b0),
        .o_s_ready(s_ready2), .o_awid(awid2), .o_awaddr(awaddr2), .o_awlen(awlen2),
        .o_awsize(awsize2), .o_awburst(awburst2), .o_awvalid(awvalid2),
        .i_awready(1'b1), .o_wdata(wdata2), .o_wstrb(wstrb2), .o_wlast(wlast2),
        .o_wvalid(wvalid2), .i_wready(1'b1), .i_bid(6'd0), .i_bresp(2'b00),
        .i_bvalid(bpend2), .o_bready(bready2), .o_busy(busy2),
        .o_init_done(done2), .o_init_error(err2), .o_words_done(words_done2)
    );

    always @(posedge clk) begin
        if (rst) bpend2 <= 1'b0;
        else if (awvalid2 && wvalid2) bpend2 <= 1'b1;
        else if (bready2) bpend2 <= 1'b0;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags"}, {57'd0, s_ready, awvalid, wvalid, bready, busy, done, err}, 64'd0);
        chk({tag, "_awaddr"}, awaddr, 64'h0);
        chk({tag, "_wdata"}, wdata, 64'h0);
        chk({tag, "_words"}, words_done, 64'd0);
    endtask

    logic [15:0] addrs [$];
    int n;

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; fill_mode = 1'b0; s_valid = 1'b0;
        fill_data = 64'd0; s_data = 64'd0; aw_delay = 0; bad_idx = -1;
        tick(); tick();
        check_reset("reset");
        rst = 1'b0;

        // ---- fill run, all readies immediate ----
        fill_mode = 1'b1; fill_data = 64'hDEADBEEF_CAFEF00D; start = 1'b1;
        tick(); start = 1'b0;
        chk("fill_first_aw", {62'd0, awvalid, wvalid}, 64'h3);
        chk("fill_wdata", wdata, 64'hDEADBEEF_CAFEF00D);
        chk("fill_consts", {awid, awlen, awsize, awburst, wstrb, wlast},
            {6'd0, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b1});
        chk("fill_busy", busy, 1);
        n = 1;
        while (!done && n < 40) begin
            if (awvalid && awready) addrs.push_back(awaddr);
            tick(); n++;
        end
        chk("fill_latency", n, 9);
        chk("fill_naddr", addrs.size(), 4);
        for (int i = 0; i < 4 && i < addrs.size(); i++) chk("fill_addr", addrs[i], 16'(i * 8));
        for (int i = 0; i < 4; i++) chk("fill_mem", mem[i], 64'hDEADBEEF_CAFEF00D);
        chk("fill_end", {busy, err, done}, 3'b001);
        chk("fill_words", words_done, 4);

        // ---- stream run, gapped valid ----
        rst = 1'b1; tick(); rst = 1'b0;
        fill_mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!s_ready && n < 20) begin tick(); n++; end
            chk("strm_ready_up", s_ready, 1);
            tick(); tick();
            chk("strm_ready_hold", {awvalid, s_ready}, 2'b01);
            s_valid = 1'b1; s_data = 64'(k + 1);
            tick(); s_valid = 1'b0;
            chk("strm_ready_down", {s_ready, awvalid}, 2'b01);
            chk("strm_wdata", wdata, 64'(k + 1));
        end
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("strm_done", {err, done}, 2'b01);
        chk("strm_words", words_done, 4);
        for (int i = 0; i < 4; i++) chk("strm_mem", mem[i], 64'(i + 1));
        chk("strm_ready_viol", ready_viol, 0);

        // ---- AW backpressure ----
        rst = 1'b1; tick(); rst = 1'b0;
        aw_delay = 3; fill_mode = 1'b1; fill_data = 64'h5555_AAAA_1234_5678; start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        while (!(awvalid && awaddr == 16'h8) && n < 40) begin tick(); n++; end
        chk("bp_reach", {awvalid, wvalid}, 2'b11);
        tick();
        chk("bp_wdrop", {awvalid, wvalid, bready}, 3'b100);
        chk("bp_addr_hold", awaddr, 16'h8);
        tick(); tick();
        chk("bp_aw_late", {awvalid, awready, wvalid}, 3'b110);
        chk("bp_addr_hold2", awaddr, 16'h8);
        n = 0;
        while (!done && n < 60) begin tick(); n++; end
        chk("bp_done", done, 1);
        chk("bp_writes", wr_cnt, 4);
        chk("bp_bcount", b_idx, 4);
        chk("bp_mem1", mem[1], 64'h5555_AAAA_1234_5678);
        aw_delay = 0;

        // ---- bad response on second word, then clean restart ----
        rst = 1'b1; tick(); rst = 1'b0;
        bad_idx = 1; fill_data = 64'h0BAD_0BAD_0BAD_0BAD; start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        while (!(done || err) && n < 40) begin tick(); n++; end
        chk("err_flags", {busy, err, done}, 3'b010);
        chk("err_words", words_done, 1);
        bad_idx = -1; fill_data = 64'h600D_600D_600D_600D; start = 1'b1;
        tick(); start = 1'b0;
        chk("err_clear", {err, done, busy}, 3'b001);
        chk("err_clear_words", words_done, 0);
        n = 0;
        while (!(done || err) && n < 40) begin tick(); n++; end
        chk("err_rerun", {err, done}, 2'b01);
        chk("err_rerun_words", words_done, 4);
        chk("err_rerun_mem", mem[3], 64'h600D_600D_600D_600D);

        // ---- start ignored in RESP, reset mid-WRITE ----
        rst = 1'b1; tick(); rst = 1'b0;
        fill_data = 64'h1111; start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        while (!bready && n < 20) begin tick(); n++; end
        chk("ign_resp", bready, 1);
        start = 1'b1; fill_mode = 1'b0;
        tick(); start = 1'b0;
        chk("ign_state", {s_ready, awvalid, wvalid}, 3'b011);
        chk("ign_addr", awaddr, 16'h8);
        chk("ign_words", words_done, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset("midrst");
        tick();
        chk("midrst_idle", {busy, s_ready, awvalid}, 3'b000);

        // ---- address wrap ----
        fill_data = 64'hFEED; start2 = 1'b1;
        tick(); start2 = 1'b0;
        chk("wrap_a0", {awvalid2, awaddr2}, {1'b1, 16'hFFF8});
        tick(); tick();
        chk("wrap_a1", {awvalid2, awaddr2}, {1'b1, 16'h0000});
        tick(); tick();
        chk("wrap_done", {err2, done2, busy2}, 3'b010);
        chk("wrap_words", words_done2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
